column_scheduler: RTL and testbench
===================================

// Module: column_scheduler
// PURPOSE
//  Sequences the three falling byte columns of Flippy Bit: spawns target bytes, advances them
//  on the fall tick, matches the player's switch value, and keeps score and game-over state.
//  Drives letterN/yposN into Display and score/game_over/correct into the top-level game FSM.
// PARAMETERS
//  ROWS         24   playfield rows; ypos range 0..ROWS-1, ROWS-1 = floor
//  SPAWN_TICKS  6    fall ticks between spawn attempts (>=2)
//  LFSR_SEED    8'hA5 nonzero seed of the letter generator
// PORTS
//  clock       in   1  system clock; all logic on rising edge
//  reset       in   1  synchronous, active-high; clears all state
//  start       in   1  pulse; IDLE->RUN, or OVER->IDLE
//  tick        in   1  one-cycle fall-tick strobe from clock divider
//  submit      in   1  one-cycle strobe: player commits user_input
//  user_input  in   8  switch value to compare
//  letter1..3  out  8  target byte of slot 0..2 (0 when inactive)
//  ypos1..3    out  5  row of slot 0..2 (0 when inactive)
//  active      out  3  slot occupied flags, bit i = slot i
//  score       out  8  matched count, saturates at 255
//  correct     out  1  one-cycle pulse on successful match
//  game_over   out  1  high while in OVER
// BEHAVIOUR
//  - Reset: state=IDLE, active=0, all letter/ypos=0, score=0, correct=0, game_over=0,
//    spawn counter=0, LFSR=LFSR_SEED. Reset wins over every other input.
//  - States: IDLE --start--> RUN (active, score, spawn counter cleared on entry);
//    RUN --any surviving slot reaches ypos==ROWS-1 after a tick--> OVER;
//    OVER --start--> IDLE. tick/submit ignored outside RUN.
//  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every clock in all states; never 0.
//  - Match (RUN, submit): target = active slot with largest ypos, tie -> lowest index.
//    If user_input==target letter: slot cleared (active=0, letter=0, ypos=0), correct=1
//    next cycle, score+1 (saturating). Mismatch or no active slot: no state change.
//  - Tick (RUN): every active slot ypos+1; spawn counter+1. When counter reaches
//    SPAWN_TICKS-1 it wraps to 0 and a spawn is attempted: lowest-index free slot gets
//    active=1, ypos=0, letter=current LFSR. No free slot: spawn dropped, counter still wraps.
//  - First tick after entering RUN always spawns (counter preset to SPAWN_TICKS-1).
//  - Simultaneous submit+tick: match evaluated on pre-tick state; matched slot cleared and
//    not advanced; free-slot search for spawn uses pre-clear occupancy (cleared slot is not
//    reused that cycle); floor check uses post-advance ypos of surviving slots.
//  - Entering OVER freezes all slots and score; outputs hold until start or reset.
//  - Latency: all outputs registered; effects visible one clock after the strobe.
//  - Reset mid-RUN: next cycle matches post-reset values exactly.
// CONFIGURATION
//  SCHED_SPEEDUP_EN defined: effective spawn interval = max(2, SPAWN_TICKS - score[7:3]),
//    recomputed at each wrap; counter compares against the effective value.
//  Not defined: interval fixed at SPAWN_TICKS; score has no effect on timing.
// TESTING
//  1 reset, start, 1 tick -> slot0 active, ypos1=0, letter1=8'hA5-derived LFSR value, active=3'b001.
//  2 slot0 letter L at ypos 5, submit L -> next cycle active[0]=0, correct=1 for 1 cycle, score=1;
//    submit L^1 instead -> no change, correct=0.
//  3 slots at ypos 7 (slot2) and 3 (slot0), submit slot0's letter -> no match; slot2's -> slot2 cleared.
//  4 no submits, ROWS-1 ticks after first spawn -> game_over=1, further ticks leave ypos1=23;
//    start -> IDLE, game_over=0.
//  5 submit+tick same cycle with 3 slots, counter at wrap -> matched slot cleared, others +1,
//    no spawn; next spawn fills the freed slot.
//  6 score forced to 255 via 255 matches, one more match -> score stays 255, correct pulses.

Source files
------------

// File: rtl/column_scheduler.sv
// column_scheduler: sequences the three falling byte columns of Flippy Bit (spawn, fall, match, score, game over).
// Optional macro SCHED_SPEEDUP_EN: spawn interval shrinks with score, floored at 2 ticks.
module column_scheduler #(
  parameter int unsigned ROWS        = 24,
  parameter int unsigned SPAWN_TICKS = 6,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       tick_i,
  input  logic       submit_i,
  input  logic [7:0] user_input_i,
  output logic [7:0] letter1_o,
  output logic [7:0] letter2_o,
  output logic [7:0] letter3_o,
  output logic [4:0] ypos1_o,
  output logic [4:0] ypos2_o,
  output logic [4:0] ypos3_o,
  output logic [2:0] active_o,
  output logic [7:0] score_o,
  output logic       correct_o,
  output logic       game_over_o
);
  localparam logic [4:0] FLOOR = 5'(ROWS - 1);
  localparam logic [7:0] SPAWN = 8'(SPAWN_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_e;

  state_e          state_q;
  logic [2:0]      act_q, act_d;
  logic [2:0][7:0] let_q, let_d;
  logic [2:0][4:0] ypos_q, ypos_d;
  logic [7:0]      score_q, cnt_q, lfsr_q, ivl;
  logic            correct_q, game_over_q;
  logic            run, match, wrap, floor_hit;
  logic [2:0]      tgt_oh, free_oh;
  logic [4:0]      best_y;
  logic [7:0]      tgt_let;

  assign run = (state_q == S_RUN);

  // Target is the lowest column; strict '>' keeps the lowest index on ties.
  always_comb begin
    tgt_oh  = '0;
    best_y  = '0;
    tgt_let = '0;
    for (int i = 0; i < 3; i++)
      if (act_q[i] && (tgt_oh == '0 || ypos_q[i] > best_y)) begin
        tgt_oh  = 3'b001 << i;
        best_y  = ypos_q[i];
        tgt_let = let_q[i];
      end
  end

  // Lowest free slot from pre-clear occupancy, so a slot freed this cycle is not refilled.
  assign free_oh = ~act_q & (act_q + 3'd1);
  assign match   = run && submit_i && (tgt_oh != '0) && (user_input_i == tgt_let);
  assign wrap    = run && tick_i && (cnt_q == ivl - 8'd1);

  always_comb begin
    act_d     = act_q;
    let_d     = let_q;
    ypos_d    = ypos_q;
    floor_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (match && tgt_oh[i]) begin
        act_d[i]  = 1'b0;
        let_d[i]  = '0;
        ypos_d[i] = '0;
      end else if (tick_i && act_q[i]) begin
        ypos_d[i] = ypos_q[i] + 5'd1;
        if (ypos_d[i] == FLOOR) floor_hit = 1'b1;
      end else if (wrap && free_oh[i]) begin
        act_d[i]  = 1'b1;
        let_d[i]  = lfsr_q;
        ypos_d[i] = '0;
      end
    end
  end

`ifdef SCHED_SPEEDUP_EN
  logic [7:0] ivl_q, ivl_new;
  assign ivl_new = ({3'b0, score_q[7:3]} + 8'd2 >= SPAWN) ? 8'd2
                                                          : SPAWN - {3'b0, score_q[7:3]};
  always_ff @(posedge clock_i) begin
    if (reset_i)                       ivl_q <= SPAWN;
    else if (!run && state_q == S_IDLE && start_i) ivl_q <= SPAWN;
    else if (wrap)                     ivl_q <= ivl_new;
  end
  assign ivl = ivl_q;
`else
  assign ivl = SPAWN;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      act_q       <= '0;
      let_q       <= '0;
      ypos_q      <= '0;
      score_q     <= '0;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      correct_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      lfsr_q    <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      correct_q <= match;
      case (state_q)
        S_IDLE: if (start_i) begin
          state_q <= S_RUN;
          act_q   <= '0;
          let_q   <= '0;
          ypos_q  <= '0;
          score_q <= '0;
          // Preset to the wrap value so the very first tick spawns.
          cnt_q   <= SPAWN - 8'd1;
        end
        S_RUN: begin
          act_q  <= act_d;
          let_q  <= let_d;
          ypos_q <= ypos_d;
          if (match && score_q != 8'hFF) score_q <= score_q + 8'd1;
          if (tick_i) cnt_q <= wrap ? 8'd0 : cnt_q + 8'd1;
          if (floor_hit) begin
            state_q     <= S_OVER;
            game_over_q <= 1'b1;
          end
        end
        S_OVER: if (start_i) begin
          state_q     <= S_IDLE;
          game_over_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign letter1_o   = let_q[0];
  assign letter2_o   = let_q[1];
  assign letter3_o   = let_q[2];
  assign ypos1_o     = ypos_q[0];
  assign ypos2_o     = ypos_q[1];
  assign ypos3_o     = ypos_q[2];
  assign active_o    = act_q;
  assign score_o     = score_q;
  assign correct_o   = correct_q;
  assign game_over_o = game_over_q;
endmodule

// File: tb/tb_column_scheduler.sv
// Bench for column_scheduler: directed scenarios plus random play against a slot-level reference model.
module tb_column_scheduler;
  localparam int ROWS = 24;
  localparam int ST   = 6;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, tick = 1'b0, submit = 1'b0;
  logic [7:0] ui = '0;
  logic [7:0] l1, l2, l3, score;
  logic [4:0] y1, y2, y3;
  logic [2:0] act;
  logic       cor, go;
  logic [51:0] dv;
  int tests = 0, fails = 0;

  column_scheduler #(.ROWS(ROWS), .SPAWN_TICKS(ST), .LFSR_SEED(8'hA5)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .tick_i(tick), .submit_i(submit),
    .user_input_i(ui), .letter1_o(l1), .letter2_o(l2), .letter3_o(l3),
    .ypos1_o(y1), .ypos2_o(y2), .ypos3_o(y3), .active_o(act), .score_o(score),
    .correct_o(cor), .game_over_o(go));

  always #5 clk = ~clk;
  assign dv = {act, l1, l2, l3, y1, y2, y3, score, cor, go};

  // Reference model: state 0 idle, 1 run, 2 over
  int         m_state, m_score, m_cnt;
  bit         m_act[3];
  logic [7:0] m_let[3];
  int         m_y[3];
  logic [7:0] m_lfsr;
  bit         m_cor;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int m_target();
    int t = -1;
    for (int i = 0; i < 3; i++)
      if (m_act[i] && (t < 0 || m_y[i] > m_y[t])) t = i;
    return t;
  endfunction

  function automatic logic [51:0] exp_vec();
    return {m_act[2], m_act[1], m_act[0], m_let[0], m_let[1], m_let[2],
            5'(m_y[0]), 5'(m_y[1]), 5'(m_y[2]), 8'(m_score), m_cor, 1'(m_state == 2)};
  endfunction

  task automatic clear_slots();
    for (int i = 0; i < 3; i++) begin m_act[i] = 0; m_let[i] = '0; m_y[i] = 0; end
  endtask

  task automatic model_step(input bit st, input bit tk, input bit sb, input logic [7:0] v);
    logic [7:0] cur;
    int t;
    bit occ[3];
    bit hit;
    cur = m_lfsr; hit = 0;
    m_lfsr = lfsr_next(m_lfsr);
    m_cor = 0;
    if (m_state == 0) begin
      if (st) begin m_state = 1; clear_slots(); m_score = 0; m_cnt = ST - 1; end
    end else if (m_state == 1) begin
      t = m_target();
      occ = m_act;
      if (sb && t >= 0 && v == m_let[t]) begin
        m_act[t] = 0; m_let[t] = '0; m_y[t] = 0; m_cor = 1;
        if (m_score < 255) m_score++;
      end
      if (tk) begin
        for (int i = 0; i < 3; i++)
          if (m_act[i]) begin m_y[i]++; if (m_y[i] == ROWS - 1) hit = 1; end
        if (m_cnt == ST - 1) begin
          m_cnt = 0;
          for (int i = 0; i < 3; i++)
            if (!occ[i]) begin m_act[i] = 1; m_y[i] = 0; m_let[i] = cur; break; end
        end else m_cnt++;
        if (hit) m_state = 2;
      end
    end else if (st) m_state = 0;
  endtask

  task automatic cycle(input bit st, input bit tk, input bit sb, input logic [7:0] v);
    @(negedge clk); start = st; tick = tk; submit = sb; ui = v;
    @(posedge clk); model_step(st, tk, sb, v);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 0; tick = 0; submit = 0; ui = $urandom;
    @(posedge clk);
    m_state = 0; m_score = 0; m_cnt = 0; m_cor = 0; m_lfsr = 8'hA5; clear_slots();
    #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0); cycle(0, 1, 0, 0);
    do_reset();
    tests++; if (dv !== 52'b0) begin fails++; $display("FAIL reset_zero: got %h want 0", dv); end
    tests++; if (dv !== exp_vec()) begin fails++; $display("FAIL reset_model: got %h want %h", dv, exp_vec()); end
  endtask

  task automatic test_first_spawn();
    cycle(1, 0, 0, 0); cycle(0, 1, 0, 0);
    tests++; if (act !== 3'b001) begin fails++; $display("FAIL spawn_active: got %b want 001", act); end
    tests++; if (l1 !== 8'h4A || y1 !== 5'd0) begin fails++; $display("FAIL spawn_letter: got %h/%0d want 4a/0", l1, y1); end
    tests++; if (dv !== exp_vec()) begin fails++; $display("FAIL spawn_model: got %h want %h", dv, exp_vec()); end
  endtask

  task automatic test_match();
    repeat (5) cycle(0, 1, 0, 0);
    tests++; if (y1 !== 5'd5) begin fails++; $display("FAIL match_ypos: got %0d want 5", y1); end
    cycle(0, 0, 1, m_let[0] ^ 8'h01);
    tests++; if (act !== 3'b001 || cor !== 1'b0 || score !== 8'd0)
      begin fails++; $display("FAIL mismatch_nochange: got act %b cor %b score %0d want 001 0 0", act, cor, score); end
    cycle(0, 0, 1, m_let[0]);
    tests++; if (act !== 3'b000 || cor !== 1'b1 || score !== 8'd1 || l1 !== 8'd0)
      begin fails++; $display("FAIL match_clear: got act %b cor %b score %0d l1 %h want 000 1 1 00", act, cor, score, l1); end
    cycle(0, 0, 0, 0);
    tests++; if (cor !== 1'b0) begin fails++; $display("FAIL correct_pulse: got %b want 0", cor); end
  endtask

  task automatic test_priority();
    do_reset(); cycle(1, 0, 0, 0);
    repeat (13) cycle(0, 1, 0, 0);
    tests++; if (act !== 3'b111 || y1 !== 5'd12 || y2 !== 5'd6 || y3 !== 5'd0)
      begin fails++; $display("FAIL prio_setup: got %b %0d %0d %0d want 111 12 6 0", act, y1, y2, y3); end
    cycle(0, 0, 1, m_let[1]);
    tests++; if (dv !== exp_vec()) begin fails++; $display("FAIL prio_nontarget: got %h want %h", dv, exp_vec()); end
    cycle(0, 0, 1, m_let[0]);
    tests++; if (act !== 3'b110) begin fails++; $display("FAIL prio_target: got %b want 110", act); end
    repeat (6) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, m_let[0]);
    tests++; if (dv !== exp_vec()) begin fails++; $display("FAIL prio_low: got %h want %h", dv, exp_vec()); end
    cycle(0, 0, 1, m_let[1]);
    tests++; if (act !== 3'b101 || dv !== exp_vec())
      begin fails++; $display("FAIL prio_high: got %h want %h", dv, exp_vec()); end
  endtask

  task automatic test_game_over();
    do_reset(); cycle(1, 0, 0, 0);
    repeat (23) cycle(0, 1, 0, 0);
    tests++; if (go !== 1'b0 || y1 !== 5'd22) begin fails++; $display("FAIL over_early: got go %b y %0d want 0 22", go, y1); end
    cycle(0, 1, 0, 0);
    tests++; if (go !== 1'b1 || y1 !== 5'd23) begin fails++; $display("FAIL over_floor: got go %b y %0d want 1 23", go, y1); end
    repeat (3) cycle(0, 1, 1, m_let[0]);
    tests++; if (go !== 1'b1 || y1 !== 5'd23 || dv !== exp_vec())
      begin fails++; $display("FAIL over_frozen: got %h want %h", dv, exp_vec()); end
    cycle(1, 0, 0, 0);
    tests++; if (go !== 1'b0) begin fails++; $display("FAIL over_restart: got %b want 0", go); end
  endtask

  task automatic test_back_to_back();
    do_reset(); cycle(1, 0, 0, 0);
    repeat (18) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, m_let[0]);
    tests++; if (act !== 3'b110 || y1 !== 5'd0 || y2 !== 5'd12 || y3 !== 5'd6 || cor !== 1'b1)
      begin fails++; $display("FAIL simul_clear: got %b %0d %0d %0d cor %b want 110 0 12 6 1", act, y1, y2, y3, cor); end
    repeat (6) cycle(0, 1, 0, 0);
    tests++; if (act !== 3'b111 || y1 !== 5'd0 || y2 !== 5'd18)
      begin fails++; $display("FAIL simul_refill: got %b %0d %0d want 111 0 18", act, y1, y2); end
    tests++; if (dv !== exp_vec()) begin fails++; $display("FAIL simul_model: got %h want %h", dv, exp_vec()); end
  endtask

  task automatic test_saturate();
    int n = 0;
    int t;
    do_reset(); cycle(1, 0, 0, 0);
    while (m_score < 255 && n < 20000) begin
      t = m_target();
      if (t < 0) cycle(0, 1, 0, 0); else cycle(0, 0, 1, m_let[t]);
      n++;
    end
    tests++; if (score !== 8'd255) begin fails++; $display("FAIL sat_reach: got %0d want 255", score); end
    while (m_target() < 0 && n < 20100) begin cycle(0, 1, 0, 0); n++; end
    t = m_target();
    cycle(0, 0, 1, (t < 0) ? 8'h00 : m_let[(t < 0) ? 0 : t]);
    tests++; if (score !== 8'd255 || cor !== 1'b1)
      begin fails++; $display("FAIL sat_hold: got score %0d cor %b want 255 1", score, cor); end
  endtask

  task automatic test_random();
    bit st, tk, sb;
    logic [7:0] v;
    int t;
    do_reset(); cycle(1, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
        tests++; if (dv !== exp_vec()) begin fails++; $display("FAIL rand_reset: got %h want %h", dv, exp_vec()); end
      end
      st = (m_state != 1) ? ($urandom_range(3) == 0) : ($urandom_range(49) == 0);
      tk = $urandom_range(1);
      sb = ($urandom_range(3) == 0);
      t  = m_target();
      v  = (t >= 0 && $urandom_range(3) != 0) ? m_let[(t < 0) ? 0 : t] : 8'($urandom);
      cycle(st, tk, sb, v);
      tests++; if (dv !== exp_vec()) begin fails++; $display("FAIL rand_step%0d: got %h want %h", k, dv, exp_vec()); end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_first_spawn();
    test_match();
    test_priority();
    test_game_over();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
